mio_bus_responder: RTL and testbench

//   Memory/IO bus responder on the slave side of the CPU data port; the CPU control unit waits on MIO_ready.

---
 rtl/mio_pkg.sv | 24 ++
 rtl/mio_bus_responder_if.sv | 24 ++
 rtl/mio_addr_decode.sv | 26 ++
 rtl/mio_bus_responder.sv | 226 ++++++++++++++++++++++
 tb/tb_mio_bus_responder.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/mio_pkg.sv
// rtl/mio_pkg.sv - shared types and constants for the memory/IO bus responder
package mio_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } mio_state_e;

    typedef enum logic [1:0] {
        RGN_RAM = 2'd0,
        RGN_IO  = 2'd1,
        RGN_ERR = 2'd2
    } mio_region_e;

    localparam int unsigned MIO_RAM_BYTES_DEF = 4096;
    localparam logic [31:0] MIO_IO_BASE_DEF   = 32'hE000_0000;

    // Wait-state counter width; every programmed wait value must fit in it
    localparam int MIO_CNT_W   = 4;
    localparam int MIO_CNT_MAX = (1 << MIO_CNT_W) - 1;

endpackage

// File: rtl/mio_bus_responder_if.sv
// rtl/mio_bus_responder_if.sv - CPU data-port request/response bundle
interface mio_bus_responder_if;

    logic        mem_req;
    logic        MemRW;
    logic [31:0] Addr_out;
    logic [31:0] Data_out;
    logic [31:0] Data_in;
    logic        MIO_ready;
    logic        bus_err;

    // CPU side drives the request, waits on MIO_ready
    modport master (
        output mem_req, MemRW, Addr_out, Data_out,
        input  Data_in, MIO_ready, bus_err
    );

    // Responder side
    modport slave (
        input  mem_req, MemRW, Addr_out, Data_out,
        output Data_in, MIO_ready, bus_err
    );

endinterface

// File: rtl/mio_addr_decode.sv
// rtl/mio_addr_decode.sv - combinational byte address to region decode
module mio_addr_decode
    import mio_pkg::*;
#(
    parameter int unsigned RAM_BYTES = MIO_RAM_BYTES_DEF,
    parameter logic [31:0] IO_BASE   = MIO_IO_BASE_DEF
) (
    input  logic [31:0] addr_i,
    output mio_region_e region_o
);

    localparam logic [31:0] RAM_LIMIT = 32'(RAM_BYTES);

    // Misalignment wins over any window; IO window is checked before RAM
    always_comb begin
        region_o = RGN_ERR;
        if (addr_i[1:0] != 2'b00) begin
            region_o = RGN_ERR;
        end else if (addr_i >= IO_BASE) begin
            region_o = RGN_IO;
        end else if (addr_i < RAM_LIMIT) begin
            region_o = RGN_RAM;
        end
    end

endmodule

// File: rtl/mio_bus_responder.sv
// rtl/mio_bus_responder.sv - CPU data-port responder: decode, strobe, wait states, four-phase ready (optional MIO_TIMEOUT_EN: io_ack-terminated IO with timeout)
module mio_bus_responder
    import mio_pkg::*;
#(
    parameter int unsigned RAM_BYTES  = MIO_RAM_BYTES_DEF,
    parameter logic [31:0] IO_BASE    = MIO_IO_BASE_DEF,
    parameter int          RAM_WAIT   = 1,
    parameter int          IO_WAIT    = 3,
    parameter int          IO_TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    mio_bus_responder_if.slave  cpu,
    output logic                ram_en,
    output logic                ram_we,
    output logic [29:0]         ram_addr,
    output logic [31:0]         ram_din,
    input  logic [31:0]         ram_dout,
    output logic                io_rd,
    output logic                io_we,
    output logic [31:0]         io_addr,
    output logic [31:0]         io_wdata,
    input  logic [31:0]         io_rdata,
    input  logic                io_ack
);

    // Elaboration-time parameter sanity
    if (RAM_WAIT < 0 || RAM_WAIT > MIO_CNT_MAX) begin : g_bad_ram_wait
        $error("mio_bus_responder: RAM_WAIT out of range 0..15");
    end
    if (IO_WAIT < 0 || IO_WAIT > MIO_CNT_MAX) begin : g_bad_io_wait
        $error("mio_bus_responder: IO_WAIT out of range 0..15");
    end
    if (RAM_BYTES == 0 || (RAM_BYTES & (RAM_BYTES - 1)) != 0) begin : g_bad_ram_bytes
        $error("mio_bus_responder: RAM_BYTES must be a power of two");
    end

    localparam logic [MIO_CNT_W-1:0] RAM_WAIT_C = MIO_CNT_W'(RAM_WAIT);

`ifdef MIO_TIMEOUT_EN
    if (IO_TIMEOUT < 1 || IO_TIMEOUT > MIO_CNT_MAX + 1) begin : g_bad_io_timeout
        $error("mio_bus_responder: IO_TIMEOUT out of range 1..16");
    end
    // Counter runs IO_TIMEOUT-1 down to 0, giving IO_TIMEOUT WAIT cycles
    localparam logic [MIO_CNT_W-1:0] IO_LOAD_C = MIO_CNT_W'(IO_TIMEOUT - 1);
`else
    localparam logic [MIO_CNT_W-1:0] IO_LOAD_C = MIO_CNT_W'(IO_WAIT);
    logic unused_io_ack;
    assign unused_io_ack = io_ack;
`endif

    mio_region_e region;

    mio_addr_decode #(
        .RAM_BYTES (RAM_BYTES),
        .IO_BASE   (IO_BASE)
    ) u_decode (
        .addr_i   (cpu.Addr_out),
        .region_o (region)
    );

    mio_state_e           state_q,   state_d;
    mio_region_e          region_q,  region_d;
    logic                 we_q,      we_d;
    logic [MIO_CNT_W-1:0] cnt_q,     cnt_d;
    logic                 ready_q,   ready_d;
    logic                 err_q,     err_d;
    logic [31:0]          data_q,    data_d;
    logic                 ram_en_q,  ram_en_d;
    logic                 ram_we_q,  ram_we_d;
    logic [29:0]          ram_addr_q, ram_addr_d;
    logic [31:0]          ram_din_q, ram_din_d;
    logic                 io_rd_q,   io_rd_d;
    logic                 io_we_q,   io_we_d;
    logic [31:0]          io_addr_q, io_addr_d;
    logic [31:0]          io_wdata_q, io_wdata_d;

    // State, counter and every output register; reset clears all of them at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            region_q   <= RGN_ERR;
            we_q       <= 1'b0;
            cnt_q      <= '0;
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
            data_q     <= '0;
            ram_en_q   <= 1'b0;
            ram_we_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_din_q  <= '0;
            io_rd_q    <= 1'b0;
            io_we_q    <= 1'b0;
            io_addr_q  <= '0;
            io_wdata_q <= '0;
        end else begin
            state_q    <= state_d;
            region_q   <= region_d;
            we_q       <= we_d;
            cnt_q      <= cnt_d;
            ready_q    <= ready_d;
            err_q      <= err_d;
            data_q     <= data_d;
            ram_en_q   <= ram_en_d;
            ram_we_q   <= ram_we_d;
            ram_addr_q <= ram_addr_d;
            ram_din_q  <= ram_din_d;
            io_rd_q    <= io_rd_d;
            io_we_q    <= io_we_d;
            io_addr_q  <= io_addr_d;
            io_wdata_q <= io_wdata_d;
        end
    end

    // Next-state and registered-output logic; strobes are one-cycle pulses by default-low
    always_comb begin
        state_d    = state_q;
        region_d   = region_q;
        we_d       = we_q;
        cnt_d      = cnt_q;
        ready_d    = ready_q;
        err_d      = err_q;
        data_d     = data_q;
        ram_en_d   = 1'b0;
        ram_we_d   = 1'b0;
        ram_addr_d = ram_addr_q;
        ram_din_d  = ram_din_q;
        io_rd_d    = 1'b0;
        io_we_d    = 1'b0;
        io_addr_d  = io_addr_q;
        io_wdata_d = io_wdata_q;

        case (state_q)
            IDLE: begin
                if (cpu.mem_req) begin
                    we_d     = cpu.MemRW;
                    region_d = region;
                    if (region == RGN_ERR) begin
                        // Faulted access answers on the next edge without touching any target
                        state_d = DONE;
                        ready_d = 1'b1;
                        err_d   = 1'b1;
                        data_d  = '0;
                    end else begin
                        state_d = ACCESS;
                        err_d   = 1'b0;
                        if (region == RGN_RAM) begin
                            ram_en_d   = 1'b1;
                            ram_we_d   = cpu.MemRW;
                            ram_addr_d = cpu.Addr_out[31:2];
                            ram_din_d  = cpu.Data_out;
                        end else begin
                            io_rd_d    = ~cpu.MemRW;
                            io_we_d    = cpu.MemRW;
                            io_addr_d  = cpu.Addr_out;
                            io_wdata_d = cpu.Data_out;
                        end
                    end
                end
            end

            ACCESS: begin
                state_d = WAIT;
                cnt_d   = (region_q == RGN_RAM) ? RAM_WAIT_C : IO_LOAD_C;
            end

            WAIT: begin
`ifdef MIO_TIMEOUT_EN
                if (region_q == RGN_IO) begin
                    if (io_ack) begin
                        state_d = DONE;
                        ready_d = 1'b1;
                        if (!we_q) begin
                            data_d = io_rdata;
                        end
                    end else if (cnt_q == '0) begin
                        state_d = DONE;
                        ready_d = 1'b1;
                        err_d   = 1'b1;
                        data_d  = '0;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end else
`endif
                if (cnt_q == '0) begin
                    state_d = DONE;
                    ready_d = 1'b1;
                    if (!we_q) begin
                        data_d = (region_q == RGN_RAM) ? ram_dout : io_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            DONE: begin
                // Four-phase: hold the response until the CPU withdraws its request
                if (!cpu.mem_req) begin
                    state_d = IDLE;
                    ready_d = 1'b0;
                    err_d   = 1'b0;
                end
            end

            default: begin
                state_d = IDLE;
                ready_d = 1'b0;
                err_d   = 1'b0;
            end
        endcase
    end

    assign cpu.Data_in   = data_q;
    assign cpu.MIO_ready = ready_q;
    assign cpu.bus_err   = err_q;
    assign ram_en        = ram_en_q;
    assign ram_we        = ram_we_q;
    assign ram_addr      = ram_addr_q;
    assign ram_din       = ram_din_q;
    assign io_rd         = io_rd_q;
    assign io_we         = io_we_q;
    assign io_addr       = io_addr_q;
    assign io_wdata      = io_wdata_q;

endmodule

// File: tb/tb_mio_bus_responder.sv
// tb/tb_mio_bus_responder.sv - directed and randomized bench for mio_bus_responder
module tb_mio_bus_responder;

    localparam int RAM_WAIT = 1;
    localparam int IO_WAIT  = 3;

    logic        clk;
    logic        rst_n;
    logic        ram_en, ram_we, io_rd, io_we, io_ack;
    logic [29:0] ram_addr;
    logic [31:0] ram_din, ram_dout, io_addr, io_wdata, io_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    int          mon_ram_rd = 0, mon_ram_wr = 0, mon_io_rd = 0, mon_io_wr = 0, mon_bad = 0;
    logic [31:0] mon_addr  = '0;
    logic [31:0] mon_wdata = '0;
    logic [31:0] model_data = '0;

    mio_bus_responder_if bus ();

    mio_bus_responder #(
        .RAM_BYTES  (4096),
        .IO_BASE    (32'hE000_0000),
        .RAM_WAIT   (RAM_WAIT),
        .IO_WAIT    (IO_WAIT),
        .IO_TIMEOUT (15)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cpu      (bus.slave),
        .ram_en   (ram_en),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_dout (ram_dout),
        .io_rd    (io_rd),
        .io_we    (io_we),
        .io_addr  (io_addr),
        .io_wdata (io_wdata),
        .io_rdata (io_rdata),
        .io_ack   (io_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe monitor sampled mid-cycle
    always @(negedge clk) begin
        if (ram_en && !ram_we) mon_ram_rd <= mon_ram_rd + 1;
        if (ram_en && ram_we)  mon_ram_wr <= mon_ram_wr + 1;
        if (io_rd)             mon_io_rd  <= mon_io_rd + 1;
        if (io_we)             mon_io_wr  <= mon_io_wr + 1;
        if ((int'(ram_en) + int'(io_rd) + int'(io_we)) > 1 || (ram_we && !ram_en))
            mon_bad <= mon_bad + 1;
        if (ram_en) begin
            mon_addr  <= {ram_addr, 2'b00};
            mon_wdata <= ram_din;
        end
        if (io_rd || io_we) begin
            mon_addr  <= io_addr;
            mon_wdata <= io_wdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".ready"}, {31'b0, bus.MIO_ready}, 32'h0);
        check({tag, ".err"},   {31'b0, bus.bus_err}, 32'h0);
        check({tag, ".data"},  bus.Data_in, 32'h0);
        check({tag, ".strobes"}, {28'b0, ram_en, ram_we, io_rd, io_we}, 32'h0);
        check({tag, ".ram_addr"}, {2'b0, ram_addr}, 32'h0);
        check({tag, ".ram_din"}, ram_din, 32'h0);
        check({tag, ".io_addr"}, io_addr, 32'h0);
        check({tag, ".io_wdata"}, io_wdata, 32'h0);
    endtask

    // Region by address rules: 0 = RAM, 1 = IO, 2 = fault
    function automatic int model_region(input logic [31:0] a);
        if (a % 4 != 0)             return 2;
        if (a >= 32'hE000_0000)     return 1;
        if (a < 32'd4096)           return 0;
        return 2;
    endfunction

    task automatic access(input string tag, input logic rw, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rdval,
                          input int hold, input bit early_drop);
        int rgn, exp_lat, edges;
        logic [31:0] exp_data, exp_strb;
        int rr0, rw0, ir0, iw0, bad0;
        rgn     = model_region(addr);
        exp_lat = (rgn == 2) ? 1 : ((rgn == 0) ? RAM_WAIT + 3 : IO_WAIT + 3);
        exp_data = (rgn == 2) ? 32'h0 : (rw ? model_data : rdval);
        exp_strb = 32'h0;
        if (rgn == 0) exp_strb = rw ? 32'h0001_0000 : 32'h0100_0000;
        if (rgn == 1) exp_strb = rw ? 32'h0000_0001 : 32'h0000_0100;
        rr0 = mon_ram_rd; rw0 = mon_ram_wr; ir0 = mon_io_rd; iw0 = mon_io_wr; bad0 = mon_bad;

        @(negedge clk);
        ram_dout     = rdval;
        io_rdata     = rdval;
        bus.MemRW    = rw;
        bus.Addr_out = addr;
        bus.Data_out = wdata;
        bus.mem_req  = 1'b1;
        edges = 0;
        while (edges < 40) begin
            @(posedge clk); #1;
            edges++;
            if (early_drop && edges == 1) bus.mem_req = 1'b0;
            if (bus.MIO_ready) break;
        end
        check({tag, ".latency"}, edges, exp_lat);
        check({tag, ".data"}, bus.Data_in, exp_data);
        check({tag, ".err"}, {31'b0, bus.bus_err}, (rgn == 2) ? 32'h1 : 32'h0);

        if (!early_drop) begin
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                check({tag, ".hold_ready"}, {31'b0, bus.MIO_ready}, 32'h1);
                check({tag, ".hold_data"}, bus.Data_in, exp_data);
            end
            @(negedge clk);
            bus.mem_req = 1'b0;
        end
        @(posedge clk); #1;
        check({tag, ".ready_drop"}, {31'b0, bus.MIO_ready}, 32'h0);
        check({tag, ".data_after"}, bus.Data_in, exp_data);
        @(negedge clk);
        check({tag, ".strobes"},
              {8'(mon_ram_rd - rr0), 8'(mon_ram_wr - rw0), 8'(mon_io_rd - ir0), 8'(mon_io_wr - iw0)},
              exp_strb);
        check({tag, ".one_strobe"}, 32'(mon_bad - bad0), 32'h0);
        if (rgn != 2) begin
            check({tag, ".addr"}, mon_addr, addr);
            if (rw) check({tag, ".wdata"}, mon_wdata, wdata);
        end
        model_data = exp_data;
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.mem_req  = 1'b0;
        bus.MemRW    = 1'b0;
        bus.Addr_out = '0;
        bus.Data_out = '0;
        ram_dout     = '0;
        io_rdata     = '0;
        io_ack       = 1'b0;
        #1;
        check_all_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        access("ram_rd",      1'b0, 32'h0000_0010, 32'h0,         32'h1234_5678, 1, 1'b0);
        access("io_wr",       1'b1, 32'hE000_0000, 32'h0000_00A5, 32'hDEAD_BEEF, 1, 1'b0);
        access("unmapped",    1'b0, 32'h0000_2000, 32'h0,         32'h5555_AAAA, 1, 1'b0);
        access("misaligned",  1'b0, 32'h0000_0002, 32'h0,         32'h5555_AAAA, 1, 1'b0);
        access("ram_hold5",   1'b0, 32'h0000_0FFC, 32'h0,         32'hCAFE_F00D, 5, 1'b0);
        access("ram_edge",    1'b0, 32'h0000_1000, 32'h0,         32'h1111_2222, 0, 1'b0);
        access("io_top",      1'b0, 32'hFFFF_FFFC, 32'h0,         32'h8765_4321, 2, 1'b0);
        access("below_io",    1'b1, 32'hDFFF_FFFC, 32'h7777_7777, 32'h0,         0, 1'b0);
        access("io_mis",      1'b1, 32'hE000_0001, 32'h7777_7777, 32'h0,         0, 1'b0);
        access("ram_wr",      1'b1, 32'h0000_0400, 32'h0BAD_C0DE, 32'h3333_4444, 0, 1'b0);
        access("early_drop",  1'b0, 32'hE000_0040, 32'h0,         32'h0F0F_0F0F, 0, 1'b1);

        // Reset mid-access: IO read sitting in its wait states
        @(negedge clk);
        io_rdata     = 32'h9999_9999;
        bus.MemRW    = 1'b0;
        bus.Addr_out = 32'hE000_0100;
        bus.mem_req  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_wait");
        bus.mem_req = 1'b0;
        model_data  = 32'h0;
        @(negedge clk);
        rst_n = 1'b1;
        access("post_rst", 1'b0, 32'h0000_0020, 32'h0, 32'h2468_ACE0, 1, 1'b0);

        for (int t = 0; t < 40; t++) begin
            logic [31:0] a;
            int c;
            c = $urandom_range(0, 4);
            case (c)
                0, 4: a = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
                1:    a = 32'hE000_0000 | ($urandom & 32'h1FFF_FFFC);
                2:    a = ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(1, 3));
                default: a = (32'h0000_1000 + ($urandom % 32'hDFFF_F000)) & 32'hFFFF_FFFC;
            endcase
            access("rand", 1'($urandom_range(0, 1)), a, $urandom, $urandom,
                   $urandom_range(0, 3), bit'($urandom_range(0, 3) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
